// File: rtl/dmem_pkg.sv
// Shared types and sizes for the i281 data-memory init/arbitration block.
package dmem_pkg;
  localparam int ADDR_W       = 4;
  localparam int DATA_W       = 8;
  localparam int NUM_BYTES    = 16;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_CPU  = 2'd2,
    SRC_DBG  = 2'd3
  } wsrc_t;
endpackage

// File: rtl/dmem_wr_arbiter.sv
// RUN-state CPU/debug write-port arbiter: CPU wins, debug forced after MAX_WAIT losses.
// Source select is combinational; ack is registered (1 cycle), one access per two cycles.
module dmem_wr_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic  i_clock,
  input  logic  i_reset,
  input  logic  i_run,
  input  logic  i_reload,
  input  logic  i_cpu_we,
  input  logic  i_dbg_req,
  input  logic  i_dbg_we,
  output wsrc_t o_src,
  output logic  o_force_stall,
  output logic  o_rd_take,
  output logic  o_ack
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_ack;
  logic              w_live;
  logic              w_dbg_wr;
  logic              w_dbg_rd;
  logic              w_force;
  wsrc_t             w_src;

  // The ack cycle never serves, so a still-high request is not taken twice.
  // The reload cycle is reserved for the CPU; debug waits until RUN returns.
  always_comb begin
    w_live   = i_run && i_dbg_req && !r_ack && !i_reload;
    w_dbg_wr = w_live && i_dbg_we;
    w_dbg_rd = w_live && !i_dbg_we;
    w_force  = w_dbg_wr && (r_wait == WAIT_W'(MAX_WAIT));
  end

  always_comb begin
    w_src = SRC_NONE;
    if (i_run) begin
      if (w_force)       w_src = SRC_DBG;
      else if (i_cpu_we) w_src = SRC_CPU;
      else if (w_dbg_wr) w_src = SRC_DBG;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wait <= '0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_dbg_rd || (w_src == SRC_DBG);
      if (w_src == SRC_DBG)
        r_wait <= '0;
      else if ((w_src == SRC_CPU) && w_dbg_wr && (r_wait != WAIT_W'(MAX_WAIT)))
        r_wait <= r_wait + 1'b1;
    end
  end

  assign o_src         = w_src;
  assign o_force_stall = w_force;
  assign o_rd_take     = w_dbg_rd;
  assign o_ack         = r_ack;
endmodule

// File: rtl/dmem_init_arbiter.sv
// Owns the data-memory write port: preset copy after reset/reload, then CPU/debug sharing.
// Copy takes NUM_BYTES cycles with CPU stalled; debug ack/read data arrive one cycle after service.
module dmem_init_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_b0I,
  input  logic [DATA_W-1:0] i_b1I,
  input  logic [DATA_W-1:0] i_b2I,
  input  logic [DATA_W-1:0] i_b3I,
  input  logic [DATA_W-1:0] i_b4I,
  input  logic [DATA_W-1:0] i_b5I,
  input  logic [DATA_W-1:0] i_b6I,
  input  logic [DATA_W-1:0] i_b7I,
  input  logic [DATA_W-1:0] i_b8I,
  input  logic [DATA_W-1:0] i_b9I,
  input  logic [DATA_W-1:0] i_b10I,
  input  logic [DATA_W-1:0] i_b11I,
  input  logic [DATA_W-1:0] i_b12I,
  input  logic [DATA_W-1:0] i_b13I,
  input  logic [DATA_W-1:0] i_b14I,
  input  logic [DATA_W-1:0] i_b15I,
  input  logic              i_reload,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dm_we,
  output logic [ADDR_W-1:0] o_dm_waddr,
  output logic [DATA_W-1:0] o_dm_wdata,
  output logic [ADDR_W-1:0] o_dm_dbg_raddr,
  input  logic [DATA_W-1:0] i_dm_dbg_rdata,
  output logic              o_init_done
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic [DATA_W-1:0] w_preset [NUM_BYTES];
  wsrc_t             w_arb_src;
  wsrc_t             w_src;
  logic              w_run;
  logic              w_force;
  logic              w_rd_take;
  logic              w_ack;

  assign w_preset = '{i_b0I, i_b1I, i_b2I,  i_b3I,  i_b4I,  i_b5I,  i_b6I,  i_b7I,
                      i_b8I, i_b9I, i_b10I, i_b11I, i_b12I, i_b13I, i_b14I, i_b15I};

  assign w_run = (r_state == RUN);

  dmem_wr_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wr_arb (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_run         (w_run),
    .i_reload      (i_reload),
    .i_cpu_we      (i_cpu_we),
    .i_dbg_req     (i_dbg_req),
    .i_dbg_we      (i_dbg_we),
    .o_src         (w_arb_src),
    .o_force_stall (w_force),
    .o_rd_take     (w_rd_take),
    .o_ack         (w_ack)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= LOAD;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      LOAD:    if (r_cnt == ADDR_W'(NUM_BYTES - 1)) w_state_nxt = RUN;
      RUN:     if (i_reload) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  always_comb begin
    w_src = w_run ? w_arb_src : SRC_LOAD;
    o_dm_waddr = '0;
    o_dm_wdata = '0;
    unique case (w_src)
      SRC_LOAD: begin o_dm_waddr = r_cnt;      o_dm_wdata = w_preset[r_cnt]; end
      SRC_CPU:  begin o_dm_waddr = i_cpu_addr; o_dm_wdata = i_cpu_wdata;     end
      SRC_DBG:  begin o_dm_waddr = i_dbg_addr; o_dm_wdata = i_dbg_wdata;     end
      default:  ;
    endcase
    // Reset overrides the LOAD-state write so memory is untouched while reset is held.
    o_dm_we     = (w_src != SRC_NONE) && !i_reset;
    o_cpu_stall = !w_run || w_force;
    o_init_done = w_run;
  end

  // The counter wraps to 0 on the last copy beat, so RUN always starts with it cleared.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          r_cnt <= '0;
    else if (!w_run)      r_cnt <= r_cnt + 1'b1;
    else if (i_reload)    r_cnt <= '0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)        r_dbg_rdata <= '0;
    else if (w_rd_take) r_dbg_rdata <= i_dm_dbg_rdata;
  end

  assign o_dm_dbg_raddr = i_dbg_addr;
  assign o_dbg_rdata    = r_dbg_rdata;
  assign o_dbg_ack      = w_ack;
endmodule

// File: tb/tb_dmem_init_arbiter.sv
// Directed plus randomized bench for dmem_init_arbiter against a cycle-level reference model.
module tb_dmem_init_arbiter;
  localparam int MAX_WAIT = 4;

  logic       clk, rst, reload, cpu_we, dbg_req, dbg_we;
  logic [3:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata;
  logic [7:0] pre [16];
  logic       cpu_stall, dbg_ack, dm_we, init_done;
  logic [7:0] dbg_rdata, dm_wdata, dm_dbg_rdata;
  logic [3:0] dm_waddr, dm_dbg_raddr;
  logic [7:0] tb_mem [16];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_load, m_ack, m_ack_rd;
  int         m_idx, m_wait;
  logic [7:0] m_rdata;
  logic [7:0] m_mem [16];

  // DUT outputs as seen at the last mid-cycle sample
  logic       s_we, s_stall, s_init, s_ack;
  logic [3:0] s_addr;
  logic [7:0] s_data, s_rdata;

  dmem_init_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_b0I(pre[0]),   .i_b1I(pre[1]),   .i_b2I(pre[2]),   .i_b3I(pre[3]),
    .i_b4I(pre[4]),   .i_b5I(pre[5]),   .i_b6I(pre[6]),   .i_b7I(pre[7]),
    .i_b8I(pre[8]),   .i_b9I(pre[9]),   .i_b10I(pre[10]), .i_b11I(pre[11]),
    .i_b12I(pre[12]), .i_b13I(pre[13]), .i_b14I(pre[14]), .i_b15I(pre[15]),
    .i_reload(reload), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_stall(cpu_stall), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
    .o_dm_we(dm_we), .o_dm_waddr(dm_waddr), .o_dm_wdata(dm_wdata),
    .o_dm_dbg_raddr(dm_dbg_raddr), .i_dm_dbg_rdata(dm_dbg_rdata), .o_init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory behind the DUT's ports
  assign dm_dbg_rdata = tb_mem[dm_dbg_raddr];
  always @(posedge clk) if (dm_we) tb_mem[dm_waddr] <= dm_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_load = 1; m_idx = 0; m_wait = 0; m_ack = 0; m_ack_rd = 0; m_rdata = '0;
  endtask

  // One clock cycle: inputs already driven just after the edge; check mid-cycle, then advance model.
  task automatic step();
    int         src;  // 0 none, 1 preset, 2 cpu, 3 debug
    bit         live, dw, dr, frc;
    logic       ewe, estall;
    logic [3:0] ea;
    logic [7:0] ed, rd_old;
    #4;
    if (rst) model_reset();
    src = 0; live = 0; dw = 0; dr = 0; frc = 0; ea = '0; ed = '0;
    if (!rst && m_load) begin
      src = 1; ea = 4'(m_idx); ed = pre[m_idx];
    end else if (!rst) begin
      live = dbg_req && !m_ack && !reload;
      dw   = live && dbg_we;
      dr   = live && !dbg_we;
      frc  = dw && (m_wait == MAX_WAIT);
      if (frc)         src = 3;
      else if (cpu_we) src = 2;
      else if (dw)     src = 3;
      if (src == 2) begin ea = cpu_addr; ed = cpu_wdata; end
      if (src == 3) begin ea = dbg_addr; ed = dbg_wdata; end
    end
    ewe    = !rst && (src != 0);
    estall = rst || m_load || frc;
    chk("dm_we", 32'(dm_we), 32'(ewe));
    if (ewe) begin
      chk("dm_waddr", 32'(dm_waddr), 32'(ea));
      chk("dm_wdata", 32'(dm_wdata), 32'(ed));
    end
    chk("cpu_stall", 32'(cpu_stall), 32'(estall));
    chk("init_done", 32'(init_done), 32'(!rst && !m_load));
    chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
    if (rst || (m_ack && m_ack_rd)) chk("dbg_rdata", 32'(dbg_rdata), 32'(m_rdata));
    if (!rst && dbg_req && !dbg_we) chk("dbg_raddr", 32'(dm_dbg_raddr), 32'(dbg_addr));
    s_we = dm_we; s_addr = dm_waddr; s_data = dm_wdata; s_stall = cpu_stall;
    s_init = init_done; s_ack = dbg_ack; s_rdata = dbg_rdata;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (m_load) begin
        m_mem[m_idx] = pre[m_idx];
        m_ack = 0; m_ack_rd = 0;
        m_idx++;
        if (m_idx == 16) begin m_load = 0; m_idx = 0; end
      end else begin
        rd_old = m_mem[dbg_addr];
        if (src != 0) m_mem[ea] = ed;
        m_ack = (src == 3) || dr;
        m_ack_rd = dr;
        if (dr) m_rdata = rd_old;
        if (src == 3) m_wait = 0;
        else if (src == 2 && dw && m_wait < MAX_WAIT) m_wait++;
        if (reload) begin m_load = 1; m_idx = 0; end
      end
    end
  endtask

  task automatic new_dbg();
    dbg_req = 1; dbg_we = 1'($urandom); dbg_addr = 4'($urandom); dbg_wdata = 8'($urandom);
  endtask

  // Random CPU traffic plus a debug requester that holds until ack, sometimes re-requesting at once.
  task automatic rand_cycle();
    cpu_we    = ($urandom_range(0, 99) < 60);
    cpu_addr  = 4'($urandom);
    cpu_wdata = 8'($urandom);
    reload    = init_done && ($urandom_range(0, 59) == 0);
    if (dbg_req && dbg_ack) begin
      if ($urandom_range(0, 3) == 0) new_dbg(); else dbg_req = 0;
    end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
      new_dbg();
    end
    step();
  endtask

  initial begin
    int n, cyc;
    logic [7:0] tp [16];
    tp = '{8'd7, 8'd3, 8'd2, 8'd1, 8'd6, 8'd4, 8'd5, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 16; i++) begin pre[i] = tp[i]; tb_mem[i] = '0; m_mem[i] = '0; end
    rst = 1; reload = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    step(); step();
    chk("reset_we", 32'(s_we), 32'd0);
    chk("reset_stall", 32'(s_stall), 32'd1);

    // Initial copy with CPU writes and a held debug read (addr 3) that must wait for RUN
    rst = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd3;
    for (int i = 0; i < 16; i++) begin
      cpu_we = 1; cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
      step();
      chk("load_addr", 32'(s_addr), 32'(i));
      chk("load_data", 32'(s_data), 32'(tp[i]));
      chk("load_stall", 32'(s_stall), 32'd1);
    end
    cpu_we = 1; cpu_addr = 4'd5; cpu_wdata = 8'hA5;
    step();
    chk("run_init_done", 32'(s_init), 32'd1);
    chk("run_stall", 32'(s_stall), 32'd0);
    chk("run_cpu_addr", 32'(s_addr), 32'd5);
    dbg_req = 0;
    step();
    chk("rd_ack", 32'(s_ack), 32'd1);
    chk("rd_data", 32'(s_rdata), 32'h01);

    // Mid-copy reset at counter 9 restarts from address 0
    reload = 1; cpu_we = 0;
    step();
    reload = 0;
    for (int i = 0; i < 9; i++) step();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("reload_addr", 32'(s_addr), 32'(i));
    end
    step();
    chk("reload_done", 32'(s_init), 32'd1);

    // Debug write on an idle port
    cpu_we = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 4'd9; dbg_wdata = 8'h2A;
    step();
    chk("dbgw_we", 32'(s_we), 32'd1);
    chk("dbgw_addr", 32'(s_addr), 32'd9);
    chk("dbgw_data", 32'(s_data), 32'h2A);
    chk("dbgw_stall", 32'(s_stall), 32'd0);
    dbg_req = 0;
    step();
    chk("dbgw_ack", 32'(s_ack), 32'd1);

    // Starvation guard: continuous CPU writes, debug forced in on the 5th cycle
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd12; dbg_wdata = 8'h5C;
    n = 0; cyc = 0;
    while (n == 0 && cyc < 10) begin
      cpu_we = 1; cpu_addr = 4'($urandom_range(0, 11)); cpu_wdata = 8'($urandom);
      step();
      cyc++;
      if (s_stall) n = cyc;
    end
    chk("force_cycle", 32'(n), 32'd5);
    chk("force_addr", 32'(s_addr), 32'd12);
    dbg_req = 0;
    step();
    chk("force_ack", 32'(s_ack), 32'd1);
    chk("force_resume", 32'(s_stall), 32'd0);

    // Reload with a coincident CPU write; held debug write only served after recopy
    cpu_we = 1; cpu_addr = 4'd7; cpu_wdata = 8'h77; reload = 1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd2; dbg_wdata = 8'h99;
    step();
    chk("rl_cpu_we", 32'(s_we), 32'd1);
    chk("rl_cpu_addr", 32'(s_addr), 32'd7);
    reload = 0; cpu_we = 0;
    n = 0; cyc = 0;
    while (n == 0 && cyc < 30) begin
      step();
      cyc++;
      if (s_ack) n = cyc;
    end
    chk("rl_ack_delay", 32'(n), 32'd18);
    dbg_req = 0;

    for (int i = 0; i < 600; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
